// File: rtl/des_out_pkg.sv
// Shared types and defaults for the DES output serializer (des_out_serializer, des_out_fifo).
// Build option: define DES_OUT_PARITY_EN to add the m_parity output.
package des_out_pkg;

  localparam int DES_DATA_WIDTH = 64;
  localparam int DES_DEPTH      = 2;
  localparam int BYTES_PER_BLK  = DES_DATA_WIDTH / 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_BLK);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/des_out_fifo.sv
// Synchronous FIFO of whole result blocks. Exposes the head block and the one behind it
// so the serializer can roll into the next block without a bubble.
module des_out_fifo
  import des_out_pkg::*;
#(
  parameter int DATA_WIDTH = DES_DATA_WIDTH,
  parameter int DEPTH      = DES_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH:1]   wr_data,
  output logic [DATA_WIDTH:1]   head_data,
  output logic [DATA_WIDTH:1]   next_data,
  output logic                  full,
  output logic                  empty,
  output logic                  multi
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH:1] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr, rd_ptr_p1;
  logic [CW-1:0]       cnt;

  assign rd_ptr_p1 = rd_ptr + PW'(1);
  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr_p1];
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign multi     = (cnt > CW'(1));

  // When full, push with pop overwrites the slot being retired this very edge.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_p1;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/des_out_serializer.sv
// Buffers DES result blocks and streams them MSB byte first over a byte-wide valid/ready link.
// Build option: define DES_OUT_PARITY_EN to add m_parity (odd parity of m_data).
module des_out_serializer
  import des_out_pkg::*;
#(
  parameter int DATA_WIDTH = DES_DATA_WIDTH,
  parameter int DEPTH      = DES_DEPTH
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [DATA_WIDTH:1] i_data,
  input  logic                i_valid,
  output logic [7:0]          m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                overflow,
`ifdef DES_OUT_PARITY_EN
  output logic                m_parity,
`endif
  output logic                dbg_state
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPB > 1) ? $clog2(BPB) : 1;

  // Handshake: a byte transfers on a rising edge where m_valid & m_ready; while m_valid is
  // high and m_ready low, m_data/m_last/m_valid hold; m_ready is ignored while m_valid is low.
  logic                hs, pop, push, ovf_set, ld;
  logic                fifo_full, fifo_empty, fifo_multi;
  logic [DATA_WIDTH:1] head_data, next_data, blk_sel, shifted;
  logic [IDX_W-1:0]    k, k_nxt;
  logic [7:0]          nxt_byte;
  state_e              state, state_nxt;

  assign hs        = m_valid & m_ready;
  assign pop       = hs & m_last;
  assign push      = i_valid & (~fifo_full | pop);
  assign ovf_set   = i_valid & fifo_full & ~pop;
  assign m_valid   = (state == S_SEND);
  assign busy      = ~fifo_empty;
  assign dbg_state = state;

  des_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (push),
    .pop       (pop),
    .wr_data   (i_data),
    .head_data (head_data),
    .next_data (next_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the block/byte that the output register loads on this edge.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    blk_sel   = head_data;
    ld        = 1'b0;
    case (state)
      S_IDLE: begin
        if (push) begin
          state_nxt = S_SEND;
          k_nxt     = '0;
          blk_sel   = i_data;
          ld        = 1'b1;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (m_last) begin
            k_nxt = '0;
            if (fifo_multi) begin
              blk_sel = next_data;
              ld      = 1'b1;
            end else if (push) begin
              blk_sel = i_data;
              ld      = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            k_nxt = k + IDX_W'(1);
            ld    = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    shifted  = blk_sel << {k_nxt, 3'b000};
    nxt_byte = shifted[DATA_WIDTH -: 8];
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      k        <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      overflow <= 1'b0;
`ifdef DES_OUT_PARITY_EN
      m_parity <= 1'b1;
`endif
    end else begin
      k        <= k_nxt;
      overflow <= overflow | ovf_set;
      if (ld) begin
        m_data <= nxt_byte;
        m_last <= (k_nxt == IDX_W'(BPB - 1));
`ifdef DES_OUT_PARITY_EN
        m_parity <= ~^nxt_byte;
`endif
      end else if (state_nxt == S_IDLE) begin
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_out_serializer.sv
// Directed bench for des_out_serializer: expected bytes are queued as blocks are driven and
// compared as the sink accepts them. Honours DES_OUT_PARITY_EN when defined.
module tb_des_out_serializer;

  logic        wr_clk_tb;
  logic        rd_rst;
  logic [63:0] i_data;
  logic        i_valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        overflow;
  logic        dbg_state;
`ifdef DES_OUT_PARITY_EN
  logic        m_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  localparam logic [63:0] BLK_A = 64'h0EB9460100C38224;
  localparam logic [63:0] BLK_B = 64'hCDB90A2E1D937C25;
  localparam logic [63:0] BLK_C = 64'h0F15D896A1FB3FA3;
  localparam logic [63:0] BLK_D = 64'h1122334455667788;
  localparam logic [63:0] BLK_E = 64'hDEADBEEF01234567;

  des_out_serializer dut (
    .rd_clk    (wr_clk_tb),
    .rd_rst    (rd_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .overflow  (overflow),
`ifdef DES_OUT_PARITY_EN
    .m_parity  (m_parity),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    wr_clk_tb = 1'b0;
    forever #5 wr_clk_tb = ~wr_clk_tb;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge wr_clk_tb);
    #1;
  endtask

  task automatic drive_on(input logic [63:0] blk, input bit accept);
    i_valid = 1'b1;
    i_data  = blk;
    if (accept)
      for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), blk[63-8*k -: 8]});
  endtask

  task automatic drive_off();
    i_valid = 1'b0;
  endtask

  task automatic step_valid(input string tag, input logic exp);
    @(negedge wr_clk_tb);
    check(tag, m_valid, exp);
    tick();
  endtask

  // scoreboard / monitor: compares every accepted byte, and holds during stalls
  logic [7:0] prev_data;
  logic       prev_last;
  logic       prev_stall = 1'b0;
  logic [8:0] e;

  always @(negedge wr_clk_tb) begin
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte", {m_last, m_data}, e);
`ifdef DES_OUT_PARITY_EN
          check("parity", m_parity, ~^e[7:0]);
`endif
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  logic rdy_pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rd_rst  = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    m_ready = 1'b0;
    tick();
    tick();
    @(negedge wr_clk_tb);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
`ifdef DES_OUT_PARITY_EN
    check("rst_parity", m_parity, 1'b1);
`endif
    tick();
    rd_rst = 1'b0;
    tick();

    // single block, 1-cycle latency, 8 bytes then idle
    m_ready = 1'b1;
    drive_on(BLK_A, 1'b1);
    step_valid("t1_lat0", 1'b0);
    drive_off();
    for (int i = 0; i < 8; i++) step_valid("t1_stream", 1'b1);
    @(negedge wr_clk_tb);
    check("t1_idle", m_valid, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_drained", exp_q.size(), 0);
    tick();

    // back-to-back blocks two cycles apart: 16 bytes without a bubble
    drive_on(BLK_A, 1'b1);
    step_valid("t2_lat0", 1'b0);
    drive_off();
    step_valid("t2_stream", 1'b1);
    drive_on(BLK_B, 1'b1);
    step_valid("t2_stream", 1'b1);
    drive_off();
    for (int i = 0; i < 14; i++) step_valid("t2_stream", 1'b1);
    @(negedge wr_clk_tb);
    check("t2_idle", m_valid, 1'b0);
    check("t2_ovf", overflow, 1'b0);
    check("t2_drained", exp_q.size(), 0);
    tick();

    // stalls inside a block
    drive_on(BLK_B, 1'b1);
    step_valid("t3_lat0", 1'b0);
    drive_off();
    for (int i = 0; i < 10; i++) begin
      m_ready = rdy_pat[i];
      step_valid("t3_stream", 1'b1);
    end
    m_ready = 1'b1;
    step_valid("t3_idle", 1'b0);
    check("t3_drained", exp_q.size(), 0);

    // overflow: third block while full and stalled is dropped
    m_ready = 1'b0;
    drive_on(BLK_D, 1'b1);
    step_valid("t4_lat0", 1'b0);
    drive_on(BLK_A, 1'b1);
    step_valid("t4_hold", 1'b1);
    drive_on(BLK_E, 1'b0);
    step_valid("t4_hold", 1'b1);
    drive_off();
    @(negedge wr_clk_tb);
    check("t4_ovf_set", overflow, 1'b1);
    check("t4_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) step_valid("t4_hold", 1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) step_valid("t4_stream", 1'b1);
    @(negedge wr_clk_tb);
    check("t4_idle", m_valid, 1'b0);
    check("t4_ovf_sticky", overflow, 1'b1);
    check("t4_drained", exp_q.size(), 0);
    tick();

    // reset after byte 3; i_valid during reset is ignored
    drive_on(BLK_A, 1'b1);
    step_valid("t6_lat0", 1'b0);
    drive_off();
    for (int i = 0; i < 4; i++) step_valid("t6_stream", 1'b1);
    rd_rst = 1'b1;
    drive_on(BLK_B, 1'b0);
    exp_q.delete();
    tick();
    rd_rst = 1'b0;
    drive_off();
    @(negedge wr_clk_tb);
    check("t6_valid", m_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_last", m_last, 1'b0);
    check("t6_data", m_data, 8'h00);
    tick();
    step_valid("t6_quiet", 1'b0);
    step_valid("t6_quiet", 1'b0);
    drive_on(BLK_A, 1'b1);
    step_valid("t6_lat0", 1'b0);
    drive_off();
    for (int i = 0; i < 8; i++) step_valid("t6_restream", 1'b1);
    step_valid("t6_idle", 1'b0);
    check("t6_drained", exp_q.size(), 0);

    // push into a full buffer on the last-byte handshake
    drive_on(BLK_A, 1'b1);
    step_valid("t5_lat0", 1'b0);
    drive_on(BLK_B, 1'b1);
    step_valid("t5_stream", 1'b1);
    drive_off();
    for (int i = 0; i < 6; i++) step_valid("t5_stream", 1'b1);
    drive_on(BLK_C, 1'b1);
    @(negedge wr_clk_tb);
    check("t5_last_now", m_last, 1'b1);
    check("t5_full_busy", busy, 1'b1);
    tick();
    drive_off();
    for (int i = 0; i < 16; i++) step_valid("t5_stream", 1'b1);
    @(negedge wr_clk_tb);
    check("t5_idle", m_valid, 1'b0);
    check("t5_ovf", overflow, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_drained", exp_q.size(), 0);
    tick();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
